// File: rtl/serdes_link_trainer_pkg.sv
// Shared types, defaults and helpers for the SerDes receive-path link trainer.
package serdes_link_trainer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WAIT_LOCK,
        ST_START,
        ST_WAIT_RDY,
        ST_CHECK,
        ST_SLIP,
        ST_STEP,
        ST_SETTLE,
        ST_DONE,
        ST_FAIL
    } state_t;

    localparam logic [3:0] DEF_PATTERN    = 4'b0011;
    localparam int         DEF_NUM_PHASES = 8;
    localparam int         DEF_LOCK_WAIT  = 1024;
    localparam int         DEF_TIMEOUT    = 65535;
    localparam int         DEF_SETTLE     = 16;
    localparam int         DEF_WINDOW     = 64;
    localparam int         DEF_STEP_PW    = 4;
    localparam logic [1:0] DEF_PHASE_SEL  = 2'd1;

    // Bits needed for a counter running 0..n-1 (never less than one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic is_busy(input state_t s);
        return !(s inside {ST_IDLE, ST_DONE, ST_FAIL});
    endfunction

endpackage

// File: rtl/serdes_pulse_gen.sv
// Fixed-width pulse generator: start launches a WIDTH-cycle registered pulse,
// abort kills it (and any pending count) on the next edge.
module serdes_pulse_gen
    import serdes_link_trainer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic abort,
    output logic pulse,
    output logic last
);

    localparam int CW = cnt_width(WIDTH);

    logic [CW-1:0] cnt_reg;
    logic          pulse_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            pulse_reg <= 1'b0;
        end else if (abort) begin
            cnt_reg   <= '0;
            pulse_reg <= 1'b0;
        end else if (start) begin
            cnt_reg   <= CW'(WIDTH - 1);
            pulse_reg <= 1'b1;
        end else if (pulse_reg) begin
            if (cnt_reg == '0)
                pulse_reg <= 1'b0;
            else
                cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign pulse = pulse_reg;
    assign last  = pulse_reg && (cnt_reg == '0);

endmodule

// File: rtl/serdes_link_trainer.sv
// Receive-path bring-up: PLL lock qualification, IDDR start, then a slip/phase
// search until the training word is seen for a full window.
module serdes_link_trainer
    import serdes_link_trainer_pkg::*;
#(
    parameter logic [3:0] PATTERN    = DEF_PATTERN,
    parameter int         NUM_PHASES = DEF_NUM_PHASES,
    parameter int         LOCK_WAIT  = DEF_LOCK_WAIT,
    parameter int         TIMEOUT    = DEF_TIMEOUT,
    parameter int         SETTLE     = DEF_SETTLE,
    parameter int         WINDOW     = DEF_WINDOW,
    parameter int         STEP_PW    = DEF_STEP_PW,
    parameter logic [1:0] PHASE_SEL  = DEF_PHASE_SEL
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       train_req,
    input  logic       pll_lock,
    input  logic       iddr_ready,
    input  logic [3:0] iddr_q,
    output logic       iddr_start,
    output logic       iddr_alignwd,
    output logic [1:0] pll_phasesel,
    output logic       pll_phasedir,
    output logic       pll_phasestep,
    output logic       pll_phaseloadreg,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic       lock_lost,
    output logic [3:0] phase_idx,
    output logic [1:0] slip_cnt
);

    localparam int LW_W  = cnt_width(LOCK_WAIT);
    localparam int TO_W  = cnt_width(TIMEOUT);
    localparam int CNT_N = (SETTLE > WINDOW) ? SETTLE : WINDOW;
    localparam int CN_W  = cnt_width(CNT_N);

    localparam logic [LW_W-1:0] LOCK_LAST   = LW_W'(LOCK_WAIT - 1);
    localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TIMEOUT - 1);
    localparam logic [CN_W-1:0] SETTLE_LAST = CN_W'(SETTLE - 1);
    localparam logic [CN_W-1:0] WINDOW_LAST = CN_W'(WINDOW - 1);
    localparam logic [3:0]      PHASE_LAST  = 4'(NUM_PHASES - 1);

    state_t          state_reg, state_next;
    logic [LW_W-1:0] lock_cnt_reg, lock_cnt_next;
    logic [TO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
    logic [CN_W-1:0] cnt_reg, cnt_next;        // settle timer, then match counter
    logic [3:0]      phase_reg, phase_next;
    logic [1:0]      slip_reg, slip_next;
    logic            step_start, step_abort, step_last;
    logic            start_reg, alignwd_reg, busy_reg, done_reg, fail_reg, lost_reg;

    always_comb begin
        state_next    = state_reg;
        lock_cnt_next = lock_cnt_reg;
        tmo_cnt_next  = tmo_cnt_reg;
        cnt_next      = cnt_reg;
        phase_next    = phase_reg;
        slip_next     = slip_reg;

        if (!is_busy(state_reg)) begin
            // Lock loss in DONE restarts exactly like a fresh request.
            if (train_req || (state_reg == ST_DONE && !pll_lock)) begin
                state_next    = ST_WAIT_LOCK;
                lock_cnt_next = '0;
                tmo_cnt_next  = '0;
                cnt_next      = '0;
                phase_next    = '0;
                slip_next     = '0;
            end
        end else if (!pll_lock && state_reg != ST_WAIT_LOCK) begin
            state_next    = ST_WAIT_LOCK;
            lock_cnt_next = '0;
            tmo_cnt_next  = '0;
            cnt_next      = '0;
        end else begin
            case (state_reg)
                ST_WAIT_LOCK: begin
                    if (pll_lock && lock_cnt_reg == LOCK_LAST) begin
                        state_next = ST_START;
                    end else if (tmo_cnt_reg == TO_LAST) begin
                        state_next = ST_FAIL;
                    end else begin
                        tmo_cnt_next  = tmo_cnt_reg + 1'b1;
                        lock_cnt_next = pll_lock ? lock_cnt_reg + 1'b1 : '0;
                    end
                end
                ST_START: begin
                    state_next   = ST_WAIT_RDY;
                    tmo_cnt_next = '0;
                end
                ST_WAIT_RDY: begin
                    if (iddr_ready) begin
                        state_next = ST_SETTLE;
                        cnt_next   = '0;
                    end else if (tmo_cnt_reg == TO_LAST) begin
                        state_next = ST_FAIL;
                    end else begin
                        tmo_cnt_next = tmo_cnt_reg + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_reg == SETTLE_LAST) begin
                        state_next = ST_CHECK;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (iddr_q == PATTERN) begin
                        if (cnt_reg == WINDOW_LAST)
                            state_next = ST_DONE;
                        else
                            cnt_next = cnt_reg + 1'b1;
                    end else if (slip_reg != 2'd3) begin
                        state_next = ST_SLIP;
                    end else if (phase_reg != PHASE_LAST) begin
                        state_next = ST_STEP;
                    end else begin
                        state_next = ST_FAIL;
                    end
                end
                ST_SLIP: begin
                    slip_next  = slip_reg + 1'b1;
                    state_next = ST_SETTLE;
                    cnt_next   = '0;
                end
                ST_STEP: begin
                    if (step_last) begin
                        phase_next = phase_reg + 1'b1;
                        slip_next  = '0;
                        state_next = ST_SETTLE;
                        cnt_next   = '0;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Pulse generator follows the STEP state; leaving STEP for any reason kills it.
    assign step_start = (state_next == ST_STEP) && (state_reg != ST_STEP);
    assign step_abort = (state_next != ST_STEP);

    serdes_pulse_gen #(
        .WIDTH (STEP_PW)
    ) u_step_pulse (
        .clk   (clk),
        .rst_n (rst_n),
        .start (step_start),
        .abort (step_abort),
        .pulse (pll_phasestep),
        .last  (step_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            lock_cnt_reg <= '0;
            tmo_cnt_reg  <= '0;
            cnt_reg      <= '0;
            phase_reg    <= '0;
            slip_reg     <= '0;
            start_reg    <= 1'b0;
            alignwd_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            fail_reg     <= 1'b0;
            lost_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            lock_cnt_reg <= lock_cnt_next;
            tmo_cnt_reg  <= tmo_cnt_next;
            cnt_reg      <= cnt_next;
            phase_reg    <= phase_next;
            slip_reg     <= slip_next;
            start_reg    <= (state_next == ST_START);
            alignwd_reg  <= (state_next == ST_SLIP);
            busy_reg     <= is_busy(state_next);
            done_reg     <= (state_next == ST_DONE);
            fail_reg     <= (state_next == ST_FAIL);
            lost_reg     <= (state_reg == ST_DONE) && !pll_lock;
        end
    end

    assign iddr_start       = start_reg;
    assign iddr_alignwd     = alignwd_reg;
    assign pll_phasesel     = PHASE_SEL;
    assign pll_phasedir     = 1'b0;
    assign pll_phaseloadreg = 1'b0;
    assign busy             = busy_reg;
    assign done             = done_reg;
    assign fail             = fail_reg;
    assign lock_lost        = lost_reg;
    assign phase_idx        = phase_reg;
    assign slip_cnt         = slip_reg;

endmodule

// File: tb/tb_serdes_link_trainer.sv
// Directed + randomized bench: a behavioural channel model reacts to slip/step
// pulses and expected search results are derived arithmetically.
module tb_serdes_link_trainer;

    localparam logic [3:0] PAT  = 4'b0011;
    localparam int         NPH  = 8;
    localparam int         LW   = 32;
    localparam int         TO   = 300;
    localparam int         STL  = 16;
    localparam int         WIN  = 24;
    localparam int         PW   = 4;
    localparam logic [1:0] PSEL = 2'd1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       train_req = 1'b0;
    logic       pll_lock = 1'b0;
    logic       iddr_ready = 1'b1;
    logic [3:0] iddr_q = 4'h0;
    logic       iddr_start, iddr_alignwd, pll_phasedir, pll_phasestep, pll_phaseloadreg;
    logic       busy, done, fail, lock_lost;
    logic [1:0] pll_phasesel, slip_cnt;
    logic [3:0] phase_idx;

    serdes_link_trainer #(
        .PATTERN (PAT), .NUM_PHASES (NPH), .LOCK_WAIT (LW), .TIMEOUT (TO),
        .SETTLE (STL), .WINDOW (WIN), .STEP_PW (PW), .PHASE_SEL (PSEL)
    ) dut (
        .clk (clk), .rst_n (rst_n), .train_req (train_req), .pll_lock (pll_lock),
        .iddr_ready (iddr_ready), .iddr_q (iddr_q), .iddr_start (iddr_start),
        .iddr_alignwd (iddr_alignwd), .pll_phasesel (pll_phasesel),
        .pll_phasedir (pll_phasedir), .pll_phasestep (pll_phasestep),
        .pll_phaseloadreg (pll_phaseloadreg), .busy (busy), .done (done), .fail (fail),
        .lock_lost (lock_lost), .phase_idx (phase_idx), .slip_cnt (slip_cnt)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    logic clr = 1'b0;
    int   good_phase = 0;
    int   good_slip = 0;
    int   slips_total, slips_here, steps_total, start_total, lost_total, bad_width, cur_width;

    function automatic logic [3:0] rotl(input logic [3:0] w, input int n);
        logic [7:0] d;
        d = {w, w} << n;
        return d[7:4];
    endfunction

    // Channel + pulse monitor, sampled 2 time units after each rising edge.
    always begin
        @(posedge clk);
        #2;
        if (clr || !rst_n) begin
            slips_total = 0; slips_here = 0; steps_total = 0; start_total = 0;
            lost_total = 0;  bad_width = 0;  cur_width = 0;
        end else begin
            if (iddr_alignwd) begin slips_total++; slips_here++; end
            if (iddr_start) start_total++;
            if (lock_lost) lost_total++;
            if (pll_phasestep) cur_width++;
            else if (cur_width != 0) begin
                if (cur_width != PW) bad_width++;
                steps_total++;
                slips_here = 0;
                cur_width  = 0;
            end
        end
        if (steps_total == good_phase)
            iddr_q = rotl(PAT, (((good_slip - slips_here) % 4) + 4) % 4);
        else begin
            logic [3:0] w;
            do w = 4'($urandom_range(0, 15)); while (w == PAT);
            iddr_q = w;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_train();
        @(negedge clk); train_req = 1'b1; clr = 1'b1;
        @(negedge clk); train_req = 1'b0; clr = 1'b0;
    endtask

    task automatic wait_end(input int budget, output int cycles);
        cycles = 0;
        while (!(done || fail) && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        chk("end_within_budget", 32'(cycles < budget), 1);
    endtask

    task automatic run_trial(input int gp, input int gs);
        int cyc;
        good_phase = gp; good_slip = gs; pll_lock = 1'b1;
        start_train();
        chk("busy_after_req", {31'b0, busy}, 1);
        wait_end(6000, cyc);
        chk("trial_done", {31'b0, done}, 1);
        chk("trial_phase_idx", {28'b0, phase_idx}, gp);
        chk("trial_slip_cnt", {30'b0, slip_cnt}, gs);
        chk("trial_alignwd_pulses", slips_total, 3 * gp + gs);
        chk("trial_step_pulses", steps_total, gp);
        chk("trial_step_width_errors", bad_width, 0);
        chk("trial_iddr_start_pulses", start_total, 1);
        $display("trial phase=%0d slip=%0d cycles=%0d done=%0b", gp, gs, cyc, done);
    endtask

    initial begin
        int cyc;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done_fail", {30'b0, done, fail}, 0);
        chk("rst_phasesel", {30'b0, pll_phasesel}, PSEL);
        chk("rst_pulses", {28'b0, iddr_start, iddr_alignwd, pll_phasestep, lock_lost}, 0);
        chk("rst_consts", {30'b0, pll_phasedir, pll_phaseloadreg}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: lock after 100 cycles, pattern already aligned
        good_phase = 0; good_slip = 0; pll_lock = 1'b0;
        start_train();
        repeat (100) @(negedge clk);
        chk("t1_no_start_before_lock", start_total, 0);
        pll_lock = 1'b1;
        wait_end(2000, cyc);
        chk("t1_done", {31'b0, done}, 1);
        chk("t1_latency_lo", 32'(cyc >= LW + STL + WIN), 1);
        chk("t1_latency_hi", 32'(cyc <= LW + STL + WIN + 4), 1);
        chk("t1_start_once", start_total, 1);
        chk("t1_no_alignwd", slips_total, 0);
        chk("t1_phase_idx", {28'b0, phase_idx}, 0);
        $display("test1 latency=%0d done=%0b", cyc, done);

        // 5: one-cycle lock drop while DONE
        @(negedge clk); pll_lock = 1'b0;
        @(negedge clk); pll_lock = 1'b1;
        chk("t5_lock_lost_pulse", {31'b0, lock_lost}, 1);
        chk("t5_busy", {30'b0, busy, done}, 2);
        @(negedge clk);
        chk("t5_lock_lost_one_cycle", {31'b0, lock_lost}, 0);
        wait_end(2000, cyc);
        chk("t5_redone", {31'b0, done}, 1);
        chk("t5_lost_count", lost_total, 1);
        chk("t5_phase_idx", {28'b0, phase_idx}, 0);
        $display("test5 retrain cycles=%0d done=%0b", cyc, done);

        // 2: word rotated by 2 at phase 3, then randomized alignment points
        run_trial(3, 2);
        for (int i = 0; i < 5; i++)
            run_trial(int'($urandom_range(0, NPH - 1)), int'($urandom_range(0, 3)));

        // 3: pattern never present
        good_phase = -1; pll_lock = 1'b1;
        start_train();
        wait_end(8000, cyc);
        chk("t3_fail", {30'b0, fail, done}, 2);
        chk("t3_phase_idx", {28'b0, phase_idx}, NPH - 1);
        chk("t3_slip_cnt", {30'b0, slip_cnt}, 3);
        chk("t3_slips", slips_total, 3 * NPH);
        chk("t3_steps", steps_total, NPH - 1);
        repeat (10) @(negedge clk);
        chk("t3_fail_held", {29'b0, fail, busy, done}, 4);
        $display("test3 search cycles=%0d fail=%0b", cyc, fail);

        // 4: lock never comes
        pll_lock = 1'b0;
        start_train();
        repeat (TO - 1) @(negedge clk);
        chk("t4_not_yet_fail", {30'b0, fail, busy}, 1);
        @(negedge clk);
        chk("t4_fail_at_timeout", {30'b0, fail, busy}, 2);
        $display("test4 timeout fail=%0b", fail);

        // 6: reset during a phase step
        good_phase = 5; good_slip = 1; pll_lock = 1'b1;
        start_train();
        cyc = 0;
        while (!pll_phasestep && cyc < 3000) begin @(negedge clk); cyc++; end
        chk("t6_step_seen", {31'b0, pll_phasestep}, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_step_killed", {31'b0, pll_phasestep}, 0);
        chk("t6_status_clear", {29'b0, busy, done, fail}, 0);
        chk("t6_counters_clear", {26'b0, phase_idx, slip_cnt}, 0);
        chk("t6_phasesel", {30'b0, pll_phasesel}, PSEL);
        @(negedge clk); rst_n = 1'b1;
        $display("test6 reset mid-step phasestep=%0b", pll_phasestep);
        run_trial(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
